// File: rtl/uart_rx_oversample.sv
// UART receiver driven by a 16x oversampling tick.
// Detects the start bit, samples every data bit at its mid-point (LSB first),
// checks the stop bit and delivers the word with a one-clock done pulse.
module uart_rx_oversample #(
    parameter int DBIT    = 8,   // data bits per frame (5..8)
    parameter int SB_TICK = 16   // ticks spent in the stop bit (16 = 1 stop, 32 = 2 stop)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // Tick counter must hold 15 for data bits and SB_TICK-1 for the stop bit.
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic [SW-1:0]   r_s_cnt;
    logic [SW-1:0]   w_s_cnt_n;
    logic [NW-1:0]   r_n_cnt;
    logic [NW-1:0]   w_n_cnt_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_n;
    logic [DBIT-1:0] r_dout;
    logic [DBIT-1:0] w_dout_n;
    logic            r_frame_err;
    logic            w_frame_err_n;
    logic            r_done;
    logic            w_done_n;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_s_cnt     <= '0;
            r_n_cnt     <= '0;
            r_b         <= '0;
            r_dout      <= '0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_s_cnt     <= w_s_cnt_n;
            r_n_cnt     <= w_n_cnt_n;
            r_b         <= w_b_n;
            r_dout      <= w_dout_n;
            r_frame_err <= w_frame_err_n;
            r_done      <= w_done_n;
        end
    end

    // Next-state logic; everything holds unless a tick (or a start edge in IDLE) moves it.
    always_comb begin
        w_state_n     = r_state;
        w_s_cnt_n     = r_s_cnt;
        w_n_cnt_n     = r_n_cnt;
        w_b_n         = r_b;
        w_dout_n      = r_dout;
        w_frame_err_n = r_frame_err;
        w_done_n      = 1'b0;
        case (r_state)
            IDLE: begin
                // Start edge is taken immediately so the half-bit count starts from the edge.
                if (!w_rx_s) begin
                    w_state_n = START;
                    w_s_cnt_n = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s_cnt == SW'(7)) begin
                        // Middle of the start bit: still low means a real frame.
                        if (!w_rx_s) begin
                            w_state_n = DATA;
                            w_s_cnt_n = '0;
                            w_n_cnt_n = '0;
                        end else begin
                            w_state_n = IDLE;
                        end
                    end else begin
                        w_s_cnt_n = r_s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s_cnt == SW'(15)) begin
                        w_s_cnt_n = '0;
                        w_b_n     = {w_rx_s, r_b[DBIT-1:1]};
                        if (r_n_cnt == NW'(DBIT - 1)) begin
                            w_state_n = STOP;
                        end else begin
                            w_n_cnt_n = r_n_cnt + NW'(1);
                        end
                    end else begin
                        w_s_cnt_n = r_s_cnt + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s_cnt == SW'(SB_TICK - 1)) begin
                        // Word is delivered even when the stop bit is low; frame_err flags it.
                        w_dout_n      = r_b;
                        w_frame_err_n = ~w_rx_s;
                        w_done_n      = 1'b1;
                        w_state_n     = IDLE;
                    end else begin
                        w_s_cnt_n = r_s_cnt + SW'(1);
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed testbench for uart_rx_oversample (DBIT=8, SB_TICK=16, tick every 41 clk).
module tb_uart_rx_oversample;

    localparam int TICK_DIV = 41;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    logic       tick_en;
    int         tick_cnt;

    int         total;
    int         bad;

    // Monitor state: rising edges of done, total high cycles, captured outputs.
    int         pulse_cnt;
    int         high_cnt;
    logic       prev_done;

    uart_rx_oversample #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running divider; tick_en gates the pulse without shifting its phase.
    always @(posedge clk) begin
        if (tick_cnt == TICK_DIV - 1) tick_cnt <= 0;
        else                          tick_cnt <= tick_cnt + 1;
    end
    assign s_tick = tick_en && (tick_cnt == 0);

    always @(negedge clk) begin
        prev_done <= rx_done_tick;
        if (rx_done_tick) high_cnt <= high_cnt + 1;
        if (rx_done_tick && !prev_done) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit at stop_lvl for stop_ticks, then idle gap.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                              input int stop_ticks, input int gap_ticks);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_lvl;
        wait_clks(stop_ticks * TICK_DIV);
        rx = 1'b1;
        wait_clks(gap_ticks * TICK_DIV);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        tick_en = 1'b1;
        wait_clks(10);
        total++;
        if (dout !== 8'h00) begin
            bad++; $display("FAIL reset_dout actual=%h required=00", dout);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_frame_err actual=%b required=0", frame_err);
        end
        total++;
        if (rx_done_tick !== 1'b0) begin
            bad++; $display("FAIL reset_done actual=%b required=0", rx_done_tick);
        end
        reset_n = 1'b1;
        wait_clks(5 * TICK_DIV);
    endtask

    task automatic test_basic();
        int p0, h0;
        p0 = pulse_cnt;
        h0 = high_cnt;
        send_frame(8'h55, 1'b1, 16, 32);
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++; $display("FAIL basic_pulses actual=%0d required=1", pulse_cnt - p0);
        end
        total++;
        if (high_cnt - h0 !== 1) begin
            bad++; $display("FAIL basic_pulse_width actual=%0d required=1", high_cnt - h0);
        end
        total++;
        if (dout !== 8'h55) begin
            bad++; $display("FAIL basic_dout actual=%h required=55", dout);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL basic_frame_err actual=%b required=0", frame_err);
        end
    endtask

    task automatic test_frame_err();
        int p0;
        p0 = pulse_cnt;
        send_frame(8'hA3, 1'b0, 12, 32);
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++; $display("FAIL ferr_pulses actual=%0d required=1", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'hA3) begin
            bad++; $display("FAIL ferr_dout actual=%h required=a3", dout);
        end
        total++;
        if (frame_err !== 1'b1) begin
            bad++; $display("FAIL ferr_frame_err actual=%b required=1", frame_err);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulse_cnt;
        rx = 1'b0;
        wait_clks(3 * TICK_DIV);
        rx = 1'b1;
        wait_clks(32 * TICK_DIV);
        total++;
        if (pulse_cnt - p0 !== 0) begin
            bad++; $display("FAIL glitch_pulses actual=%0d required=0", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'hA3) begin
            bad++; $display("FAIL glitch_dout_hold actual=%h required=a3", dout);
        end
        total++;
        if (frame_err !== 1'b1) begin
            bad++; $display("FAIL glitch_ferr_hold actual=%b required=1", frame_err);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulse_cnt;
        send_frame(8'h00, 1'b1, 16, 0);
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++; $display("FAIL b2b_first_pulses actual=%0d required=1", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'h00) begin
            bad++; $display("FAIL b2b_first_dout actual=%h required=00", dout);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL b2b_first_ferr actual=%b required=0", frame_err);
        end
        send_frame(8'hFF, 1'b1, 16, 32);
        total++;
        if (pulse_cnt - p0 !== 2) begin
            bad++; $display("FAIL b2b_second_pulses actual=%0d required=2", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'hFF) begin
            bad++; $display("FAIL b2b_second_dout actual=%h required=ff", dout);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL b2b_second_ferr actual=%b required=0", frame_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         p0;
        logic [7:0] d;
        d  = 8'h3C;
        p0 = pulse_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = d[4];
        wait_clks(300);
        reset_n = 1'b0;
        wait_clks(5);
        total++;
        if (dout !== 8'h00) begin
            bad++; $display("FAIL midrst_dout_in_reset actual=%h required=00", dout);
        end
        reset_n = 1'b1;
        rx      = 1'b1;
        wait_clks(32 * TICK_DIV);
        total++;
        if (pulse_cnt - p0 !== 0) begin
            bad++; $display("FAIL midrst_no_pulse actual=%0d required=0", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'h00) begin
            bad++; $display("FAIL midrst_dout_after actual=%h required=00", dout);
        end
        send_frame(8'h81, 1'b1, 16, 32);
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++; $display("FAIL midrst_next_pulses actual=%0d required=1", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'h81) begin
            bad++; $display("FAIL midrst_next_dout actual=%h required=81", dout);
        end
    endtask

    task automatic test_tick_stall();
        int p0;
        p0      = pulse_cnt;
        tick_en = 1'b0;
        rx      = 1'b0;
        wait_clks(2000);
        total++;
        if (pulse_cnt - p0 !== 0) begin
            bad++; $display("FAIL stall_no_pulse actual=%0d required=0", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'h81) begin
            bad++; $display("FAIL stall_dout_hold actual=%h required=81", dout);
        end
        tick_en = 1'b1;
        send_frame(8'h96, 1'b1, 16, 32);
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++; $display("FAIL stall_resume_pulses actual=%0d required=1", pulse_cnt - p0);
        end
        total++;
        if (dout !== 8'h96) begin
            bad++; $display("FAIL stall_resume_dout actual=%h required=96", dout);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL stall_resume_ferr actual=%b required=0", frame_err);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        pulse_cnt = 0;
        high_cnt  = 0;
        prev_done = 1'b0;
        tick_cnt  = 0;
        tick_en   = 1'b1;
        rx        = 1'b1;
        reset_n   = 1'b0;
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame (valid 5..8).
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning sample ticks spent in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Port clk, input, 1, system clock; one clock domain; all logic is rising-edge.
REQ-004 Port reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port s_tick, input, 1, one-clk enable pulse at 16x the baud rate, from the baud tick generator.
REQ-006 Port rx, input, 1, asynchronous serial line; idles high.
REQ-007 Port dout, output, DBIT, last received data word.
REQ-008 Port rx_done_tick, output, 1, one-clk pulse marking a completed frame.
REQ-009 Port frame_err, output, 1, stop-bit sample of the last frame was low.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, reset to 1; all decisions SHALL use the synchronized value rx_s.
REQ-011 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-012 Counters SHALL be: s_cnt, 4 bits for ticks, wide enough for SB_TICK-1 in STOP; n_cnt, ceil(log2(DBIT)) bits; shift register b, DBIT bits.
REQ-013 IDLE: when rx_s==0, the FSM SHALL go to START with s_cnt=0 on that clk, independent of s_tick.
REQ-014 IDLE: s_tick SHALL be ignored.
REQ-015 START, on s_tick with s_cnt==7: rx_s==0 SHALL go to DATA with s_cnt=0 and n_cnt=0; rx_s==1 (glitch) SHALL go to IDLE with no output change.
REQ-016 START, on s_tick with s_cnt!=7: s_cnt SHALL increment.
REQ-017 DATA, on s_tick with s_cnt==15: s_cnt SHALL clear and b SHALL load {rx_s, b[DBIT-1:1]}, i.e. LSB first.
REQ-018 In the REQ-017 case, if n_cnt==DBIT-1 the FSM SHALL go to STOP, else n_cnt SHALL increment.
REQ-019 DATA, on any other s_tick: s_cnt SHALL increment.
REQ-020 Each data bit SHALL therefore be sampled at its mid-point, 16 ticks after the previous sample.
REQ-021 STOP, on s_tick with s_cnt==SB_TICK-1: dout SHALL load b, frame_err SHALL load ~rx_s, rx_done_tick SHALL assert, and the FSM SHALL go to IDLE, all on the same clk edge.
REQ-022 STOP, on any other s_tick: s_cnt SHALL increment.
REQ-023 A frame with a low stop bit SHALL still be delivered: dout updates and rx_done_tick pulses.
REQ-024 rx_done_tick SHALL be high for exactly one clk per frame, and SHALL be registered.
REQ-025 dout and frame_err SHALL hold their values between completions.
REQ-026 Without s_tick pulses, counters and state SHALL hold; only the IDLE->START transition may occur.
REQ-027 Back-to-back frames: a start edge in the first clk after returning to IDLE SHALL be accepted with no lost frame.
REQ-028 Latency: rx_done_tick SHALL occur on the s_tick that is 7+16*DBIT+SB_TICK ticks after the START entry tick count begins.

Reset
REQ-029 While reset_n==0, state SHALL be IDLE, s_cnt=0, n_cnt=0, b=0, dout=0, rx_done_tick=0, frame_err=0, and both sync flops=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame: no rx_done_tick, dout unchanged from its reset value 0.
REQ-031 After reset_n rises, the first valid start bit SHALL be received normally.

Verification
REQ-032 s_tick every 41 clk; send 0x55, 1 stop bit high -> one rx_done_tick, dout=0x55, frame_err=0.
REQ-033 Send 0xA3 with stop bit driven low -> rx_done_tick pulses, dout=0xA3, frame_err=1.
REQ-034 rx low for 3 ticks then high -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
REQ-035 Send 0x00 then 0xFF back-to-back with 1 stop bit -> two pulses, dout=0x00 then 0xFF, frame_err=0 both times.
REQ-036 reset_n pulsed low during data bit 4 of 0x3C, then 0x81 sent -> no pulse for 0x3C; a single pulse with dout=0x81.
REQ-037 s_tick held low with rx low -> FSM stays in START, no output change; ticks resumed mid-bit -> frame completes with correct dout.
